// File: rtl/interrupt_controller.sv
// interrupt_controller: IF/IE request latching, IME with delayed EI, priority vectoring.
// Optional debug port int_chipscope is enabled by defining INT_CHIPSCOPE_EN.
module interrupt_controller #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter logic [15:0] VECTOR_STRIDE = 16'd8
) (
    input  logic        cpu_clock,
    input  logic        reset,
    input  logic [4:0]  int_src,
    inout  wire  [7:0]  data_ext,
    input  logic        addr_in_IF,
    input  logic        addr_in_IE,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic        ei,
    input  logic        di,
    input  logic        reti,
    input  logic        instr_done,
    input  logic        int_ack,
    output logic        int_req,
    output logic        int_pending,
`ifdef INT_CHIPSCOPE_EN
    output logic [15:0] int_chipscope,
`endif
    output logic [15:0] int_vector
);
    typedef enum logic [1:0] {IDLE, ARMED, ENABLED} ime_state_e;

    ime_state_e  state_q;
    logic [4:0]  if_q, if_d, src_prev_q, rise, pend, clr;
    logic [7:0]  ie_q;
    logic [2:0]  idx;
    logic        ime, ei_pend, ack;

    assign ime         = state_q == ENABLED;
    assign ei_pend     = state_q == ARMED;
    assign rise        = int_src & ~src_prev_q;
    assign pend        = ie_q[4:0] & if_q;
    assign int_pending = |pend;
    assign int_req     = ime & int_pending;
    assign ack         = int_ack & int_req;
    assign int_vector  = int_pending ? VECTOR_BASE + VECTOR_STRIDE * {13'd0, idx} : 16'd0;

    always_comb begin
        idx = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (pend[i]) idx = 3'(i);
    end

    // New rising edges are OR-ed in last so they survive a clearing write or acknowledge.
    assign clr  = ack ? 5'd1 << idx : 5'd0;
    assign if_d = (((mem_we & addr_in_IF) ? data_ext[4:0] : if_q) & ~clr) | rise;

    assign data_ext = (mem_re & addr_in_IF) ? {3'b111, if_q} :
                      (mem_re & addr_in_IE) ? ie_q : 8'hzz;

`ifdef INT_CHIPSCOPE_EN
    assign int_chipscope = {if_q, ie_q[4:0], ime, ei_pend, int_req, int_ack, int_pending, 1'b0};
`endif

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            if_q       <= 5'd0;
            ie_q       <= 8'd0;
            src_prev_q <= 5'd0;
        end else begin
            src_prev_q <= int_src;
            if_q       <= if_d;
            if (mem_we & addr_in_IE) ie_q <= data_ext;
            if (di)
                state_q <= IDLE;
            else if (reti)
                state_q <= ENABLED;
            else
                case (state_q)
                    IDLE:    if (ei) state_q <= ARMED;
                    ARMED:   if (instr_done) state_q <= ENABLED;
                    ENABLED: if (ack) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vector table, hand sequences and randomized run
// checked against a behavioural model of the interrupt controller.
module tb_interrupt_controller;
    logic        cpu_clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  int_src = 5'd0;
    wire  [7:0]  data_ext;
    logic [7:0]  bus_drv = 8'd0;
    logic        bus_oe = 1'b0;
    logic        addr_in_IF = 1'b0, addr_in_IE = 1'b0, mem_we = 1'b0, mem_re = 1'b0;
    logic        ei = 1'b0, di = 1'b0, reti = 1'b0, instr_done = 1'b0, int_ack = 1'b0;
    logic        int_req, int_pending;
    logic [15:0] int_vector;
`ifdef INT_CHIPSCOPE_EN
    logic [15:0] int_chipscope;
`endif
    int          checks = 0, errors = 0;

    logic [4:0]  m_if, m_prev;
    logic [7:0]  m_ie;
    logic        m_ime, m_armed;
    logic [7:0]  rd_if, rd_ie;

    typedef struct {
        logic [4:0]  src;
        logic        wif, wie;
        logic [7:0]  bus;
        logic        e, d, r, idn, ack;
        logic        req, pend;
        logic [15:0] vec;
        logic [7:0]  ifr, ier;
    } vec_t;
    vec_t tbl[30];

    assign data_ext = bus_oe ? bus_drv : 8'hzz;
    always #5 cpu_clock = ~cpu_clock;

    interrupt_controller dut (
        .cpu_clock(cpu_clock), .reset(reset), .int_src(int_src), .data_ext(data_ext),
        .addr_in_IF(addr_in_IF), .addr_in_IE(addr_in_IE), .mem_we(mem_we), .mem_re(mem_re),
        .ei(ei), .di(di), .reti(reti), .instr_done(instr_done), .int_ack(int_ack),
        .int_req(int_req), .int_pending(int_pending),
`ifdef INT_CHIPSCOPE_EN
        .int_chipscope(int_chipscope),
`endif
        .int_vector(int_vector)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [4:0] p);
        for (int k = 0; k < 5; k++)
            if (p[k]) return k;
        return -1;
    endfunction

    task automatic model_edge(input logic [4:0] src, input logic wif, input logic wie,
                              input logic [7:0] bus, input logic e, input logic d, input logic r,
                              input logic idn, input logic ack, input logic rst);
        logic [4:0] nif;
        int k;
        logic acked;
        if (rst) begin
            m_if = 0; m_ie = 0; m_prev = 0; m_ime = 0; m_armed = 0;
        end else begin
            k = lowest(m_ie[4:0] & m_if);
            acked = ack && m_ime && k >= 0;
            nif = wif ? bus[4:0] : m_if;
            if (acked) nif[k] = 1'b0;
            m_if = nif | (src & ~m_prev);
            if (wie) m_ie = bus;
            m_prev = src;
            if (d) begin m_ime = 0; m_armed = 0; end
            else if (r) begin m_ime = 1; m_armed = 0; end
            else if (m_armed) begin if (idn) begin m_ime = 1; m_armed = 0; end end
            else if (m_ime) begin if (acked) m_ime = 0; end
            else if (e) m_armed = 1;
        end
    endtask

    task automatic drive(input logic [4:0] src, input logic wif, input logic wie,
                         input logic [7:0] bus, input logic e, input logic d, input logic r,
                         input logic idn, input logic ack, input logic rst);
        int k;
        int_src = src; mem_we = wif | wie; addr_in_IF = wif; addr_in_IE = wie;
        bus_oe = wif | wie; bus_drv = bus;
        ei = e; di = d; reti = r; instr_done = idn; int_ack = ack; reset = rst;
        @(posedge cpu_clock);
        model_edge(src, wif, wie, bus, e, d, r, idn, ack, rst);
        #1;
        mem_we = 0; addr_in_IF = 0; addr_in_IE = 0; bus_oe = 0;
        ei = 0; di = 0; reti = 0; instr_done = 0; int_ack = 0; reset = 0;
        k = lowest(m_ie[4:0] & m_if);
        check("model_pending", int_pending, k >= 0);
        check("model_req", int_req, m_ime && k >= 0);
        check("model_vector", int_vector, k < 0 ? 0 : 64 + 8 * k);
        mem_re = 1; addr_in_IF = 1;
        #1 rd_if = data_ext;
        addr_in_IF = 0; addr_in_IE = 1;
        #1 rd_ie = data_ext;
        mem_re = 0; addr_in_IE = 0;
        check("model_if_read", rd_if, {3'b111, m_if});
        check("model_ie_read", rd_ie, m_ie);
    endtask

    initial begin
        //          src   wif wie bus    e  d  r  idn ack req pend vec       ifr    ier
        tbl[0]  = '{5'h00, 0, 1, 8'h08, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hE0, 8'h08};
        tbl[1]  = '{5'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 8'hE0, 8'h08};
        tbl[2]  = '{5'h08, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 16'h0058, 8'hE8, 8'h08};
        tbl[3]  = '{5'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 8'hE0, 8'h08};
        tbl[4]  = '{5'h00, 1, 0, 8'h1F, 0, 0, 0, 0, 0, 0, 1, 16'h0058, 8'hFF, 8'h08};
        tbl[5]  = '{5'h00, 0, 1, 8'h1F, 0, 0, 1, 0, 0, 1, 1, 16'h0040, 8'hFF, 8'h1F};
        tbl[6]  = '{5'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 16'h0048, 8'hFE, 8'h1F};
        tbl[7]  = '{5'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 16'h0048, 8'hFE, 8'h1F};
        tbl[8]  = '{5'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 16'h0048, 8'hFE, 8'h1F};
        tbl[9]  = '{5'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 16'h0048, 8'hFE, 8'h1F};
        tbl[10] = '{5'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 16'h0048, 8'hFE, 8'h1F};
        tbl[11] = '{5'h00, 0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 16'h0048, 8'hFE, 8'h1F};
        tbl[12] = '{5'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 16'h0048, 8'hFE, 8'h1F};
        tbl[13] = '{5'h04, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 16'h0050, 8'hE4, 8'h1F};
        tbl[14] = '{5'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 16'h0050, 8'hE4, 8'h1F};
        tbl[15] = '{5'h04, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 16'h0050, 8'hE4, 8'h1F};
        tbl[16] = '{5'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hE0, 8'h1F};
        tbl[17] = '{5'h01, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 8'hE1, 8'h1F};
        tbl[18] = '{5'h01, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 8'hE1, 8'h1F};
        tbl[19] = '{5'h01, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hE0, 8'h1F};
        tbl[20] = '{5'h01, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hE0, 8'h1F};
        tbl[21] = '{5'h01, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hE0, 8'h1F};
        tbl[22] = '{5'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hE0, 8'h1F};
        tbl[23] = '{5'h01, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 8'hE1, 8'h1F};
        tbl[24] = '{5'h00, 0, 1, 8'h01, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 8'hE1, 8'h01};
        tbl[25] = '{5'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 16'h0040, 8'hE1, 8'h01};
        tbl[26] = '{5'h00, 0, 1, 8'hE1, 0, 0, 0, 0, 0, 1, 1, 16'h0040, 8'hE1, 8'hE1};
        tbl[27] = '{5'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1, 16'h0040, 8'hE1, 8'hE1};
        tbl[28] = '{5'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 16'h0040, 8'hE1, 8'hE1};
        tbl[29] = '{5'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 16'h0040, 8'hE1, 8'hE1};

        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("reset_req", int_req, 0);
        check("reset_pending", int_pending, 0);
        check("reset_vector", int_vector, 0);
        check("reset_if_read", rd_if, 8'hE0);
        check("reset_ie_read", rd_ie, 8'h00);

        foreach (tbl[n]) begin
            drive(tbl[n].src, tbl[n].wif, tbl[n].wie, tbl[n].bus, tbl[n].e, tbl[n].d,
                  tbl[n].r, tbl[n].idn, tbl[n].ack, 0);
            check($sformatf("row%0d_req", n), int_req, tbl[n].req);
            check($sformatf("row%0d_pending", n), int_pending, tbl[n].pend);
            check($sformatf("row%0d_vector", n), int_vector, tbl[n].vec);
            check($sformatf("row%0d_if_read", n), rd_if, tbl[n].ifr);
            check($sformatf("row%0d_ie_read", n), rd_ie, tbl[n].ier);
        end

        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("pre_reset_req", int_req, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("mid_dispatch_reset_req", int_req, 0);
        check("mid_dispatch_reset_pending", int_pending, 0);
        check("mid_dispatch_reset_vector", int_vector, 0);
        check("mid_dispatch_reset_if", rd_if, 8'hE0);
        check("mid_dispatch_reset_ie", rd_ie, 8'h00);

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] src;
            logic wif, wie;
            src = ($urandom % 4 == 0) ? 5'($urandom) : int_src;
            wif = ($urandom % 10 == 0);
            wie = !wif && ($urandom % 12 == 0);
            drive(src, wif, wie, 8'($urandom), $urandom % 6 == 0, $urandom % 15 == 0,
                  $urandom % 15 == 0, $urandom % 3 == 0, $urandom % 4 == 0,
                  $urandom % 400 == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects interrupt request pulses from the peripheral blocks into the IF register (FF0F) and masks them with IE (FFFF).
- Sources: vblank, LCD STAT, timer, serial (link_cable_interrupt from the link cable block), joypad.
- Holds the master enable (IME) with the one-instruction EI delay.
- Presents the highest-priority enabled request and its vector to the CPU core, and clears the serviced IF bit on acknowledge.

Parameters:
- VECTOR_BASE, 16'h0040, address of the vblank vector (bit 0).
- VECTOR_STRIDE, 8, byte spacing between consecutive vectors.

Ports:
- cpu_clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- int_src  input  5  request lines: [0] vblank, [1] stat, [2] timer, [3] serial, [4] joypad.
- data_ext  inout  8  shared CPU data bus.
- addr_in_IF  input  1  decoded address hit for FF0F.
- addr_in_IE  input  1  decoded address hit for FFFF.
- mem_we  input  1  bus write strobe.
- mem_re  input  1  bus read strobe.
- ei  input  1  one-cycle pulse: EI executed.
- di  input  1  one-cycle pulse: DI executed.
- reti  input  1  one-cycle pulse: RETI executed.
- instr_done  input  1  one-cycle pulse at each instruction boundary.
- int_ack  input  1  one-cycle pulse: CPU begins dispatch.
- int_req  output  1  IME & (IE & IF) != 0.
- int_pending  output  1  (IE & IF) != 0, ignores IME; used for HALT wake.
- int_vector  output  16  vector of the lowest-numbered pending, enabled bit.

Behaviour:
- Reset: IF = 0, IE = 0, IME = 0, ei_pend = 0, src_prev = 0. int_req, int_pending, int_vector = 0. data_ext is high-Z.
- Edge detect:
  - rise[i] = int_src[i] & ~src_prev[i]; src_prev <= int_src every cycle.
  - A rise sampled at edge N sets IF[i] at that same edge, so the bit is visible from cycle N+1.
  - A level held high sets the bit once only.
- IF write (mem_we & addr_in_IF): IF <= data_ext[4:0] | rise. A rising edge wins over a simultaneous write of 0.
- IE write (mem_we & addr_in_IE): IE <= data_ext (all 8 bits stored).
- Reads:
  - mem_re & addr_in_IF drives {3'b111, IF}.
  - mem_re & addr_in_IE drives IE.
  - Otherwise data_ext is high-Z.
  - Both hits together must not occur; the controller is not required to handle it.
- Priority: lowest set bit of (IE[4:0] & IF) wins. int_vector = VECTOR_BASE + idx*VECTOR_STRIDE, giving 0040/0048/0050/0058/0060. int_vector = 0 when nothing is pending.
- Outputs int_req, int_pending and int_vector are combinational from the registered state.
- IME state machine, states IDLE (IME=0), ARMED (ei_pend=1), ENABLED (IME=1):
  - IDLE --ei--> ARMED.
  - ARMED --instr_done--> ENABLED. The instr_done in the same cycle as ei does not count.
  - ARMED --di--> IDLE.
  - any --reti--> ENABLED immediately.
  - any --di--> IDLE. di wins over ei and reti in the same cycle.
  - ENABLED --int_ack--> IDLE.
- Acknowledge:
  - int_ack while int_req = 1: clear IF[idx] for the idx shown at that edge, and clear IME.
  - A rise of the same bit in the same cycle keeps the bit set (set wins).
  - int_ack while int_req = 0 is ignored.
- IE[7:5] are stored but never participate in requests.
- Reset asserted mid-dispatch returns every register to its reset value on the next edge.

Optional Feature:
- Macro INT_CHIPSCOPE_EN.
- Defined: adds output port int_chipscope [15:0] = {IF, IE[4:0], IME, ei_pend, int_req, int_ack, int_pending, 1'b0} for the logic analyser.
- Undefined: the port and its logic are absent; functional behaviour is identical.

Test Plan:
- Reset, then pulse int_src[3] for one cycle with IE = 8'h08, IME = 1 -> IF reads 8'hE8 next cycle; int_req = 1; int_vector = 16'h0058.
- IF = 5'h1F, IE = 8'h1F, IME = 1 -> int_vector = 16'h0040; after int_ack: IF = 5'h1E, int_req = 0, int_pending = 1.
- ei pulse, then first instr_done -> IME = 1 only after that instr_done; ei with instr_done in the same cycle -> IME stays 0 until the next instr_done.
- Write IF = 8'h00 in the same cycle as an int_src[2] rise -> IF = 5'h04. int_ack for bit 2 coincident with a new bit-2 rise -> IF[2] stays 1.
- Hold int_src[0] high for 10 cycles, clear IF by write at cycle 3 -> IF[0] stays 0 (no retrigger); low then high again -> IF[0] = 1.
- IME = 0, IE = 8'h01, IF[0] = 1 -> int_pending = 1, int_req = 0. Then reti -> int_req = 1 next cycle. Assert reset -> all outputs 0, IE reads 8'h00.
